// File: rtl/mbist_pkg.sv
// mbist_pkg: March C- element, FSM state and per-element attribute tables
package mbist_pkg;
  typedef enum logic [2:0] {M0, M1, M2, M3, M4, M5} elem_e;
  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_DONE} state_e;
  localparam logic [5:0] ELEM_DOWN = 6'b011000;
  localparam logic [5:0] ELEM_RD   = 6'b111110;
  localparam logic [5:0] ELEM_WR   = 6'b011111;
  localparam logic [5:0] ELEM_RBG  = 6'b010100;
  localparam logic [5:0] ELEM_WBG  = 6'b001010;
endpackage

// File: rtl/mbist_cmp_pipe.sv
// mbist_cmp_pipe: aligns read expectations with memory latency and records mismatches
module mbist_cmp_pipe
  import mbist_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned ADDR_WIDTH = 4,
  parameter int unsigned CNT_WIDTH  = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  clr_i,
  input  logic                  load_i,
  input  logic                  exp_i,
  input  logic [ADDR_WIDTH-1:0] addr_i,
  input  elem_e                 elem_i,
  input  logic [DATA_WIDTH-1:0] rdata_i,
  output logic                  fail_o,
  output logic [ADDR_WIDTH-1:0] fail_addr_o,
  output logic [2:0]            fail_elem_o,
  output logic [CNT_WIDTH-1:0]  fail_count_o
);
  logic [1:0] v_q, e_q;
  logic [ADDR_WIDTH-1:0] a_q [2];
  elem_e m_q [2];
  logic fail_q, mismatch;
  logic [ADDR_WIDTH-1:0] fa_q;
  elem_e fe_q;
  logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
  // stage-2 compare against the all-zeros/all-ones background, saturating count
  always_comb begin
    mismatch = v_q[1] && rdata_i != {DATA_WIDTH{e_q[1]}};
    cnt_d = &cnt_q ? cnt_q : cnt_q + CNT_WIDTH'(1);
  end
  // shift expectations each cycle; first mismatch location is captured once
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      v_q <= '0;
      e_q <= '0;
      a_q[0] <= '0;
      a_q[1] <= '0;
      m_q[0] <= M0;
      m_q[1] <= M0;
      fail_q <= 1'b0;
      fa_q <= '0;
      fe_q <= M0;
      cnt_q <= '0;
    end else begin
      v_q <= {v_q[0], load_i};
      e_q <= {e_q[0], exp_i};
      a_q[0] <= addr_i;
      a_q[1] <= a_q[0];
      m_q[0] <= elem_i;
      m_q[1] <= m_q[0];
      if (clr_i) begin
        fail_q <= 1'b0;
        fa_q <= '0;
        fe_q <= M0;
        cnt_q <= '0;
      end else if (mismatch) begin
        fail_q <= 1'b1;
        cnt_q <= cnt_d;
        if (!fail_q) begin
          fa_q <= a_q[1];
          fe_q <= m_q[1];
        end
      end
    end
  end
  assign fail_o = fail_q;
  assign fail_addr_o = fa_q;
  assign fail_elem_o = fe_q;
  assign fail_count_o = cnt_q;
endmodule

// File: rtl/mbist_march_ctrl.sv
// mbist_march_ctrl: March C- sequencer driving fault_mem, with result capture
module mbist_march_ctrl
  import mbist_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned ADDR_WIDTH = 4,
  parameter int unsigned LAST_ADDR  = 15,
  parameter int unsigned CNT_WIDTH  = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  output logic                  write_read,
  output logic [ADDR_WIDTH-1:0] address,
  output logic [DATA_WIDTH-1:0] wdata,
  input  logic [DATA_WIDTH-1:0] rdata,
  output logic                  busy,
  output logic                  done,
  output logic                  fail,
  output logic [ADDR_WIDTH-1:0] fail_addr,
  output logic [2:0]            fail_elem,
  output logic [CNT_WIDTH-1:0]  fail_count
);
  localparam logic [ADDR_WIDTH-1:0] LAST = ADDR_WIDTH'(LAST_ADDR);
  state_e state_q;
  elem_e elem_q, elem_d;
  logic [ADDR_WIDTH-1:0] addr_q, step_d, first_d;
  logic [DATA_WIDTH-1:0] wdata_q;
  logic wr_q, drain_q, busy_q, done_q, at_end, read_half, launch, rd_issue;
  // next-op decode: step within the element or jump to the next element's first address
  always_comb begin
    elem_d = elem_q == M5 ? M5 : elem_e'(elem_q + 3'd1);
    at_end = ELEM_DOWN[elem_q] ? addr_q == '0 : addr_q == LAST;
    read_half = ELEM_RD[elem_q] && ELEM_WR[elem_q] && !wr_q;
    step_d = ELEM_DOWN[elem_q] ? addr_q - ADDR_WIDTH'(1) : addr_q + ADDR_WIDTH'(1);
    first_d = ELEM_DOWN[elem_d] ? LAST : '0;
    launch = start && (state_q == S_IDLE || state_q == S_DONE);
    rd_issue = state_q == S_RUN && !wr_q;
  end
  // march sequencer: one memory op per cycle, then two drain cycles for in-flight reads
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      elem_q <= M0;
      addr_q <= '0;
      wr_q <= 1'b0;
      wdata_q <= '0;
      drain_q <= 1'b0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
    end else begin
      case (state_q)
        S_RUN: begin
          if (read_half) begin
            wr_q <= 1'b1;
          end else if (!at_end) begin
            addr_q <= step_d;
            wr_q <= !ELEM_RD[elem_q];
          end else if (elem_q == M5) begin
            state_q <= S_DRAIN;
            wr_q <= 1'b0;
            drain_q <= 1'b0;
          end else begin
            elem_q <= elem_d;
            addr_q <= first_d;
            wr_q <= !ELEM_RD[elem_d];
            wdata_q <= {DATA_WIDTH{ELEM_WBG[elem_d]}};
          end
        end
        S_DRAIN: begin
          drain_q <= 1'b1;
          if (drain_q) begin
            state_q <= S_DONE;
            busy_q <= 1'b0;
            done_q <= 1'b1;
          end
        end
        default: begin
          if (launch) begin
            state_q <= S_RUN;
            elem_q <= M0;
            addr_q <= '0;
            wr_q <= 1'b1;
            wdata_q <= {DATA_WIDTH{ELEM_WBG[M0]}};
            busy_q <= 1'b1;
            done_q <= 1'b0;
          end
        end
      endcase
    end
  end
  mbist_cmp_pipe #(
    .DATA_WIDTH(DATA_WIDTH),
    .ADDR_WIDTH(ADDR_WIDTH),
    .CNT_WIDTH (CNT_WIDTH)
  ) u_cmp (
    .clk         (clk),
    .rst_n       (rst_n),
    .clr_i       (launch),
    .load_i      (rd_issue),
    .exp_i       (ELEM_RBG[elem_q]),
    .addr_i      (addr_q),
    .elem_i      (elem_q),
    .rdata_i     (rdata),
    .fail_o      (fail),
    .fail_addr_o (fail_addr),
    .fail_elem_o (fail_elem),
    .fail_count_o(fail_count)
  );
  assign write_read = wr_q;
  assign address = addr_q;
  assign wdata = wdata_q;
  assign busy = busy_q;
  assign done = done_q;
endmodule

// File: tb/tb_mbist_march_ctrl.sv
// tb_mbist_march_ctrl: scoreboarded March C- trace and fault-detection checks
module tb_mbist_march_ctrl;
  localparam int N = 16;
  typedef struct packed {logic wr; logic [3:0] a; logic [7:0] d;} op_t;
  logic clk = 1'b0, rst_n = 1'b0, start = 1'b0;
  logic write_read, busy, done, fail;
  logic [3:0] address, fail_addr;
  logic [7:0] wdata, fail_count;
  logic [7:0] rdata = 8'h00, wd_q = 8'h00, rd1 = 8'h00;
  logic [2:0] fail_elem;
  logic [7:0] mem [16];
  int tests = 0, fails = 0, fault_mode = 0;
  op_t exp_q[$];
  always #5 clk = ~clk;
  mbist_march_ctrl dut (
    .clk(clk), .rst_n(rst_n), .start(start), .write_read(write_read),
    .address(address), .wdata(wdata), .rdata(rdata), .busy(busy), .done(done),
    .fail(fail), .fail_addr(fail_addr), .fail_elem(fail_elem), .fail_count(fail_count)
  );
  // memory model: wdata registered a cycle early, 2-cycle read latency, optional fault
  always @(posedge clk) begin
    wd_q <= wdata;
    rd1 <= mem[address] | ((fault_mode == 1 && address == 4'd9) ? 8'h01 : 8'h00);
    rdata <= rd1;
    if (write_read) begin
      mem[address] <= wd_q;
      if (fault_mode == 2 && address == 4'd4 && !mem[4][5] && wd_q[5]) mem[5][5] <= ~mem[5][5];
    end
  end
  initial for (int i = 0; i < 16; i++) mem[i] = 8'h00;

  task automatic push_march();
    logic [3:0] a;
    logic [7:0] bg;
    for (int e = 0; e < 6; e++)
      for (int i = 0; i < N; i++) begin
        a = (e == 3 || e == 4) ? 4'(N - 1 - i) : 4'(i);
        bg = (e == 1 || e == 3) ? 8'hFF : 8'h00;
        if (e != 0) exp_q.push_back({1'b0, a, bg});
        if (e != 5) exp_q.push_back({1'b1, a, bg});
      end
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
  endtask

  task automatic wait_done(output int edges);
    edges = 0;
    while (!done && edges < 400) begin
      @(posedge clk);
      #1 edges++;
    end
    if (!done) begin
      tests++;
      fails++;
      $display("FAIL done_timeout: done=%0b after %0d cycles, want 1", done, edges);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1 tests++;
    if ({write_read, address, wdata, busy, done, fail, fail_addr, fail_elem, fail_count} !== '0) begin
      fails++;
      $display("FAIL reset_outputs: wr=%0b a=%0d d=%h busy=%0b done=%0b fail=%0b fa=%0d fe=%0d fc=%0d, want all 0",
               write_read, address, wdata, busy, done, fail, fail_addr, fail_elem, fail_count);
    end
    rst_n = 1'b1;
    repeat (2) @(posedge clk);
    #1 tests++;
    if ({busy, done, write_read} !== 3'b000) begin
      fails++;
      $display("FAIL idle_hold: busy=%0b done=%0b wr=%0b, want 0 0 0", busy, done, write_read);
    end
  endtask

  task automatic test_fault_free();
    op_t e;
    int edges;
    fault_mode = 0;
    push_march();
    pulse_start();
    for (int i = 0; i < 10 * N; i++) begin
      e = exp_q.pop_front();
      tests++;
      if ({write_read, address, wdata} !== e) begin
        fails++;
        $display("FAIL trace op%0d: wr=%0b a=%0d d=%h, want wr=%0b a=%0d d=%h",
                 i, write_read, address, wdata, e.wr, e.a, e.d);
      end
      @(posedge clk);
      #1;
    end
    tests++;
    if ({busy, done, write_read, address} !== {3'b100, 4'd15}) begin
      fails++;
      $display("FAIL drain: busy=%0b done=%0b wr=%0b a=%0d, want 1 0 0 15", busy, done, write_read, address);
    end
    wait_done(edges);
    tests++;
    if (10 * N + edges != 162) begin
      fails++;
      $display("FAIL done_latency: %0d cycles after start, want 162", 10 * N + edges);
    end
    tests++;
    if ({busy, fail, fail_count} !== 10'd0) begin
      fails++;
      $display("FAIL clean_result: busy=%0b fail=%0b fc=%0d, want 0 0 0", busy, fail, fail_count);
    end
  endtask

  task automatic test_start_ignored();
    op_t e;
    int edges;
    fault_mode = 0;
    push_march();
    pulse_start();
    for (int i = 0; i < 10 * N; i++) begin
      e = exp_q.pop_front();
      tests++;
      if ({write_read, address, wdata} !== e) begin
        fails++;
        $display("FAIL busy_start op%0d: wr=%0b a=%0d d=%h, want wr=%0b a=%0d d=%h",
                 i, write_read, address, wdata, e.wr, e.a, e.d);
      end
      start = (i == 53);
      @(posedge clk);
      #1 start = 1'b0;
    end
    wait_done(edges);
    tests++;
    if (10 * N + edges != 162 || fail !== 1'b0) begin
      fails++;
      $display("FAIL busy_start_done: latency=%0d fail=%0b, want 162 0", 10 * N + edges, fail);
    end
  endtask

  task automatic test_stuck();
    int edges;
    fault_mode = 1;
    pulse_start();
    wait_done(edges);
    tests++;
    if ({fail, fail_addr, fail_elem, fail_count} !== {1'b1, 4'd9, 3'd1, 8'd3}) begin
      fails++;
      $display("FAIL stuck_at: fail=%0b fa=%0d fe=%0d fc=%0d, want 1 9 1 3", fail, fail_addr, fail_elem, fail_count);
    end
  endtask

  task automatic test_coupling();
    int edges;
    fault_mode = 2;
    pulse_start();
    wait_done(edges);
    tests++;
    if ({fail, fail_addr, fail_elem, fail_count} !== {1'b1, 4'd5, 3'd1, 8'd2}) begin
      fails++;
      $display("FAIL coupling: fail=%0b fa=%0d fe=%0d fc=%0d, want 1 5 1 2", fail, fail_addr, fail_elem, fail_count);
    end
  endtask

  task automatic test_back_to_back();
    int edges;
    fault_mode = 0;
    pulse_start();
    tests++;
    if ({done, fail, fail_count, busy, write_read, address, wdata} !== {2'b00, 8'd0, 2'b11, 4'd0, 8'h00}) begin
      fails++;
      $display("FAIL restart: done=%0b fail=%0b fc=%0d busy=%0b wr=%0b a=%0d d=%h, want 0 0 0 1 1 0 00",
               done, fail, fail_count, busy, write_read, address, wdata);
    end
    wait_done(edges);
    tests++;
    if (edges != 162 || {fail, fail_count} !== 9'd0) begin
      fails++;
      $display("FAIL restart_done: latency=%0d fail=%0b fc=%0d, want 162 0 0", edges, fail, fail_count);
    end
  endtask

  task automatic test_reset_mid();
    int edges;
    fault_mode = 1;
    pulse_start();
    repeat (93) @(posedge clk);
    #1 tests++;
    if ({write_read, address, wdata} !== {1'b1, 4'd9, 8'hFF}) begin
      fails++;
      $display("FAIL m3_position: wr=%0b a=%0d d=%h, want 1 9 ff", write_read, address, wdata);
    end
    rst_n = 1'b0;
    @(posedge clk);
    #1 tests++;
    if ({write_read, address, wdata, busy, done, fail, fail_addr, fail_elem, fail_count} !== '0) begin
      fails++;
      $display("FAIL mid_reset: wr=%0b a=%0d d=%h busy=%0b done=%0b fail=%0b fa=%0d fe=%0d fc=%0d, want all 0",
               write_read, address, wdata, busy, done, fail, fail_addr, fail_elem, fail_count);
    end
    rst_n = 1'b1;
    repeat (2) @(posedge clk);
    #1 tests++;
    if ({fail, fail_count, busy} !== 10'd0) begin
      fails++;
      $display("FAIL flush: fail=%0b fc=%0d busy=%0b, want 0 0 0", fail, fail_count, busy);
    end
    fault_mode = 0;
    pulse_start();
    wait_done(edges);
    tests++;
    if ({done, fail, fail_count} !== {2'b10, 8'd0}) begin
      fails++;
      $display("FAIL post_reset_run: done=%0b fail=%0b fc=%0d, want 1 0 0", done, fail, fail_count);
    end
  endtask

  initial begin
    test_reset();
    test_fault_free();
    test_start_ignored();
    test_stuck();
    test_coupling();
    test_back_to_back();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
